// File: rtl/msdf_to_bin.sv
// msdf_to_bin: MSDF digit stream to two's-complement word converter.
// On-the-fly conversion with Q/QM registers and a one-word output stage.
module msdf_to_bin #(
    parameter int TARGET_PRECISION = 25,
    localparam int W = TARGET_PRECISION + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   dataInArray_0,
    input  logic         pValidArray_0,
    output logic         readyArray_0,
    output logic [W-1:0] dataOutArray_0,
    output logic         validArray_0,
    input  logic         nReadyArray_0
);

    localparam int JW = $clog2(TARGET_PRECISION + 1);
    localparam logic [JW-1:0] J_MAX = JW'(TARGET_PRECISION);
    localparam logic [W-1:0] QM_INIT = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ACC,
        HOLD
    } state_t;

    state_t state, state_next;

    logic [W-1:0]  q, qm, q_upd, qm_upd, m;
    logic [W-1:0]  data_q;
    logic [JW-1:0] j, j_upd;
    logic [1:0]    digit;
    logic          last, take;

    assign last  = dataInArray_0[2];
    assign digit = dataInArray_0[1:0];
    assign take  = pValidArray_0 & readyArray_0;

    assign validArray_0   = (state == HOLD);
    assign dataOutArray_0 = data_q;

    // Next state and input-side ready; a held word retires when downstream is ready.
    always_comb begin
        state_next   = state;
        readyArray_0 = 1'b1;
        unique case (state)
            ACC: begin
                if (take && last) state_next = HOLD;
            end
            HOLD: begin
                readyArray_0 = nReadyArray_0;
                if (nReadyArray_0) state_next = (take && last) ? HOLD : ACC;
            end
            default: state_next = ACC;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ACC;
        else     state <= state_next;
    end

    // One conversion step; digits past the converted precision leave Q/QM alone.
    always_comb begin
        m      = '0;
        q_upd  = q;
        qm_upd = qm;
        j_upd  = j;
        if (j < J_MAX) begin
            m     = ONE << (J_MAX - JW'(1) - j);
            j_upd = j + JW'(1);
            unique case (1'b1)
                (digit == 2'b01): begin
                    q_upd  = q | m;
                    qm_upd = q;
                end
                (digit == 2'b11): q_upd = qm | m;
                default:          qm_upd = qm | m;
            endcase
        end
    end

    // Converter registers and output word; a last digit publishes Q and restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= '0;
            qm     <= QM_INIT;
            j      <= '0;
            data_q <= '0;
        end else if (take) begin
            if (last) begin
                data_q <= q_upd;
                q      <= '0;
                qm     <= QM_INIT;
                j      <= '0;
            end else begin
                q  <= q_upd;
                qm <= qm_upd;
                j  <= j_upd;
            end
        end
    end

endmodule
